// File: rtl/rst_seq_pkg.sv
// Shared types and helpers for the reset sequencer.
package rst_seq_pkg;

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    RELEASE = 2'd1,
    UP      = 2'd2
  } chan_state_t;

  localparam int TIMER_W  = 26;
  localparam int RETRIG_W = 8;

  // Bits needed to hold values up to max(a, b) - 1; never less than one bit.
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/rst_seq_if.sv
// Request/status bundle between the reset sequencer and its surroundings.
interface rst_seq_if
  import rst_seq_pkg::*;
#(
  parameter int NCHAN = 3,
  parameter int NCOND = 4,
  parameter int NEXT  = 2
) ();

  logic [NEXT-1:0]     ext_rstn;
  logic [NCOND-1:0]    cond;
  logic [NCHAN-1:0]    sw_rst_req;
  logic                global_rst_n;
  logic [NCHAN-1:0]    rst_n;
  logic [RETRIG_W-1:0] retrig_cnt;

  modport master (
    output ext_rstn, cond, sw_rst_req,
    input  global_rst_n, rst_n, retrig_cnt
  );

  modport slave (
    input  ext_rstn, cond, sw_rst_req,
    output global_rst_n, rst_n, retrig_cnt
  );

endinterface

// File: rtl/rst_seq_chan.sv
// One sequenced reset channel: minimum hold, release delay, then up.
//   state   | meaning
//   HOLD    | rst_n low, counting out the minimum hold time
//   RELEASE | rst_n low, enable seen, counting the release delay
//   UP      | rst_n high until enable drops or software requests a reset
module rst_seq_chan
  import rst_seq_pkg::*;
#(
  parameter int MIN_HOLD  = 16,
  parameter int REL_DELAY = 4
) (
  input  logic bus_clk,
  input  logic bus_reset,
  input  logic en,
  input  logic sw_req,
  output logic rst_n,
  output logic retrig
);

  localparam int CW = cnt_width(MIN_HOLD, REL_DELAY);
  localparam logic [CW-1:0] HOLD_LAST = CW'(MIN_HOLD - 1);
  localparam logic [CW-1:0] REL_LAST  = CW'(REL_DELAY - 1);

  chan_state_t    state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;

  always_ff @(posedge bus_clk) begin
    if (bus_reset) begin
      state_q <= HOLD;
      cnt_q   <= '0;
      rst_n   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rst_n   <= (state_d == UP);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    retrig  = 1'b0;
    case (state_q)
      HOLD: begin
        if (sw_req) begin
          cnt_d = '0;
        end else if (cnt_q == HOLD_LAST) begin
          if (en) begin
            state_d = RELEASE;
            cnt_d   = '0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RELEASE: begin
        if (sw_req || !en) begin
          state_d = HOLD;
          cnt_d   = '0;
        end else if (cnt_q == REL_LAST) begin
          state_d = UP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      UP: begin
        if (sw_req || !en) begin
          state_d = HOLD;
          cnt_d   = '0;
          retrig  = 1'b1;
        end
      end
      default: begin
        state_d = HOLD;
        cnt_d   = '0;
      end
    endcase
  end

endmodule

// File: rtl/rst_seq.sv
// Reset sequencer top: input synchronizers, power-on timer, per-channel
// release FSMs and a saturating retrigger counter.
module rst_seq
  import rst_seq_pkg::*;
#(
  parameter int                         NCHAN       = 3,
  parameter int                         NCOND       = 4,
  parameter int                         NEXT        = 2,
  parameter int                         SYNC_STAGES = 2,
  parameter logic [TIMER_W-1:0]         STOP_COUNT  = 26'h3ffffff,
  parameter int                         MIN_HOLD    = 16,
  parameter int                         REL_DELAY   = 4,
  parameter logic [NCHAN*NCOND-1:0]     CHAN_MASK   = '1,
  parameter int                         ORDERED     = 1
) (
  input logic       bus_clk,
  input logic       bus_reset,
  rst_seq_if.slave  bus
);

  localparam int SUM_W = $clog2(NCHAN + 1);

  logic [NCOND-1:0]    cond_sync [SYNC_STAGES];
  logic [NEXT-1:0]     ext_sync  [SYNC_STAGES];
  logic [NCOND-1:0]    cond_s;
  logic [NEXT-1:0]     ext_s;
  logic [TIMER_W-1:0]  timer_q;
  logic                global_q;
  logic [NCHAN-1:0]    en, rst_n_w, retrig_p;
  logic [SUM_W-1:0]    retrig_sum;
  logic [RETRIG_W:0]   retrig_total;
  logic [RETRIG_W-1:0] retrig_q;

  always_ff @(posedge bus_clk) begin
    if (bus_reset) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        cond_sync[s] <= '0;
        ext_sync[s]  <= '0;
      end
    end else begin
      cond_sync[0] <= bus.cond;
      ext_sync[0]  <= bus.ext_rstn;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        cond_sync[s] <= cond_sync[s-1];
        ext_sync[s]  <= ext_sync[s-1];
      end
    end
  end

  assign cond_s = cond_sync[SYNC_STAGES-1];
  assign ext_s  = ext_sync[SYNC_STAGES-1];

  // Gating with ext_s makes global_rst_n drop one cycle after a request.
  always_ff @(posedge bus_clk) begin
    if (bus_reset) begin
      timer_q  <= '0;
      global_q <= 1'b0;
    end else begin
      if (!(&ext_s)) begin
        timer_q <= '0;
      end else if (timer_q != STOP_COUNT) begin
        timer_q <= timer_q + 1'b1;
      end
      global_q <= (&ext_s) && (timer_q == STOP_COUNT);
    end
  end

  for (genvar i = 0; i < NCHAN; i++) begin : g_chan
    logic prev_up;
    logic cond_ok;

    if (ORDERED != 0 && i > 0) begin : g_ordered
      assign prev_up = rst_n_w[i-1];
    end else begin : g_free
      assign prev_up = 1'b1;
    end

    assign cond_ok = &(cond_s | ~CHAN_MASK[i*NCOND +: NCOND]);
    assign en[i]   = global_q & cond_ok & prev_up;

    rst_seq_chan #(
      .MIN_HOLD  (MIN_HOLD),
      .REL_DELAY (REL_DELAY)
    ) u_chan (
      .bus_clk   (bus_clk),
      .bus_reset (bus_reset),
      .en        (en[i]),
      .sw_req    (bus.sw_rst_req[i]),
      .rst_n     (rst_n_w[i]),
      .retrig    (retrig_p[i])
    );
  end

  always_comb begin
    retrig_sum = '0;
    for (int i = 0; i < NCHAN; i++) begin
      retrig_sum = retrig_sum + SUM_W'(retrig_p[i]);
    end
  end

  assign retrig_total = {1'b0, retrig_q} + (RETRIG_W+1)'(retrig_sum);

  always_ff @(posedge bus_clk) begin
    if (bus_reset) begin
      retrig_q <= '0;
    end else begin
      retrig_q <= retrig_total[RETRIG_W] ? {RETRIG_W{1'b1}} : retrig_total[RETRIG_W-1:0];
    end
  end

  assign bus.global_rst_n = global_q;
  assign bus.rst_n        = rst_n_w;
  assign bus.retrig_cnt   = retrig_q;

endmodule

// File: tb/tb_rst_seq.sv
// Directed bench for rst_seq with a timestamp-based reference model.
module tb_rst_seq;
  import rst_seq_pkg::*;

  localparam int NCHAN       = 3;
  localparam int NCOND       = 4;
  localparam int NEXT        = 2;
  localparam int SYNC_STAGES = 2;
  localparam int STOP_CNT    = 15;
  localparam int MIN_HOLD    = 4;
  localparam int REL_DELAY   = 2;
  localparam logic [3:0] MASK [NCHAN] = '{4'b0011, 4'b0111, 4'b1111};

  logic bus_clk;
  logic bus_reset;

  rst_seq_if #(.NCHAN(NCHAN), .NCOND(NCOND), .NEXT(NEXT)) bus_if ();

  rst_seq #(
    .NCHAN       (NCHAN),
    .NCOND       (NCOND),
    .NEXT        (NEXT),
    .SYNC_STAGES (SYNC_STAGES),
    .STOP_COUNT  (26'd15),
    .MIN_HOLD    (MIN_HOLD),
    .REL_DELAY   (REL_DELAY),
    .CHAN_MASK   (12'hF73),
    .ORDERED     (1)
  ) dut (
    .bus_clk   (bus_clk),
    .bus_reset (bus_reset),
    .bus       (bus_if)
  );

  initial begin
    bus_clk = 1'b0;
    forever #5 bus_clk = ~bus_clk;
  end

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  function automatic void check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Reference model: channel timing kept as cycle timestamps, power-on
  // timer as the length of the current run of synchronized-high ext requests.
  logic [3:0] m_sc [SYNC_STAGES];
  logic [1:0] m_se [SYNC_STAGES];
  int  m_run;
  bit  m_glob;
  bit  m_up    [NCHAN];
  int  m_thold [NCHAN];
  int  m_arm   [NCHAN];
  int  m_retrig;

  task automatic model_step();
    bit e [NCHAN];
    bit prev;
    bit sw;
    int k;
    if (bus_reset) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        m_sc[s] = '0;
        m_se[s] = '0;
      end
      m_run = 0;
      m_glob = 1'b0;
      m_retrig = 0;
      for (int i = 0; i < NCHAN; i++) begin
        m_up[i] = 1'b0;
        m_thold[i] = cyc + 1;
        m_arm[i] = -1;
      end
    end else begin
      for (int i = 0; i < NCHAN; i++) begin
        if (i == 0) prev = 1'b1;
        else prev = m_up[i-1];
        e[i] = m_glob && ((m_sc[SYNC_STAGES-1] & MASK[i]) == MASK[i]) && prev;
      end
      k = 0;
      for (int i = 0; i < NCHAN; i++) begin
        sw = bus_if.sw_rst_req[i];
        if (m_up[i]) begin
          if (!e[i] || sw) begin
            m_up[i] = 1'b0;
            m_thold[i] = cyc + 1;
            m_arm[i] = -1;
            k++;
          end
        end else if (sw) begin
          m_thold[i] = cyc + 1;
          m_arm[i] = -1;
        end else if (m_arm[i] >= 0) begin
          if (!e[i]) begin
            m_thold[i] = cyc + 1;
            m_arm[i] = -1;
          end else if (cyc - m_arm[i] == REL_DELAY) begin
            m_up[i] = 1'b1;
            m_arm[i] = -1;
          end
        end else if (e[i] && cyc >= m_thold[i] + MIN_HOLD - 1) begin
          m_arm[i] = cyc;
        end
      end
      m_retrig = (m_retrig + k > 255) ? 255 : m_retrig + k;
      if (&m_se[SYNC_STAGES-1]) m_run = (m_run < 100000) ? m_run + 1 : m_run;
      else m_run = 0;
      m_glob = (m_run >= STOP_CNT + 1);
      for (int s = SYNC_STAGES - 1; s > 0; s--) begin
        m_sc[s] = m_sc[s-1];
        m_se[s] = m_se[s-1];
      end
      m_sc[0] = bus_if.cond;
      m_se[0] = bus_if.ext_rstn;
    end
    cyc++;
  endtask

  initial begin
    forever begin
      @(posedge bus_clk);
      model_step();
    end
  end

  task automatic compare_step();
    int exp_rst;
    exp_rst = 0;
    for (int i = 0; i < NCHAN; i++) if (m_up[i]) exp_rst |= (1 << i);
    check("model_rst_n", int'(bus_if.rst_n), exp_rst);
    check("model_global", int'(bus_if.global_rst_n), int'(m_glob));
    check("model_retrig", int'(bus_if.retrig_cnt), m_retrig);
  endtask

  initial begin
    forever begin
      @(negedge bus_clk);
      compare_step();
    end
  end

  task automatic next_cycle();
    @(posedge bus_clk);
    #1;
  endtask

  task automatic wait_all_up(input int budget);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge bus_clk);
      if (bus_if.rst_n === 3'b111) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("all_up_timeout", 0, 1);
  endtask

  int r0, g, t0, rise_k, fall_k, grise_k;
  bit seen;

  initial begin
    bus_reset = 1'b1;
    bus_if.ext_rstn = 2'b11;
    bus_if.cond = 4'hf;
    bus_if.sw_rst_req = '0;
    repeat (3) @(posedge bus_clk);
    #1;
    check("reset_rst_n", int'(bus_if.rst_n), 0);
    check("reset_global", int'(bus_if.global_rst_n), 0);
    check("reset_retrig", int'(bus_if.retrig_cnt), 0);
    bus_reset = 1'b0;
    r0 = cyc;

    // Power-up: global after 2 sync + 16 timer cycles, then staggered channels.
    g = -1;
    for (int k = 0; k < 100; k++) begin
      @(negedge bus_clk);
      if (bus_if.global_rst_n === 1'b1) begin
        g = cyc;
        break;
      end
    end
    check("power_on_delay", g - r0, 18);
    repeat (2) @(negedge bus_clk);
    check("pu_g2", int'(bus_if.rst_n), 0);
    @(negedge bus_clk);
    check("pu_g3", int'(bus_if.rst_n), 1);
    repeat (2) @(negedge bus_clk);
    check("pu_g5", int'(bus_if.rst_n), 1);
    @(negedge bus_clk);
    check("pu_g6", int'(bus_if.rst_n), 3);
    repeat (2) @(negedge bus_clk);
    check("pu_g8", int'(bus_if.rst_n), 3);
    @(negedge bus_clk);
    check("pu_g9", int'(bus_if.rst_n), 7);

    // cond[2] low: channels 1 and 2 drop together.
    next_cycle();
    bus_if.cond = 4'b1011;
    repeat (6) @(negedge bus_clk);
    check("cond2_rst_n", int'(bus_if.rst_n), 1);
    check("cond2_retrig", int'(bus_if.retrig_cnt), 2);
    next_cycle();
    bus_if.cond = 4'hf;
    wait_all_up(80);

    // Software reset of channel 2 only.
    next_cycle();
    bus_if.sw_rst_req = 3'b100;
    next_cycle();
    bus_if.sw_rst_req = '0;
    rise_k = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge bus_clk);
      if (k == 1) check("sw_fall", int'(bus_if.rst_n), 3);
      if (bus_if.rst_n[2] === 1'b1 && rise_k == 0) rise_k = k;
    end
    check("sw_req_to_rise", rise_k, 7);
    check("sw_retrig", int'(bus_if.retrig_cnt), 3);

    // One-cycle external reset pulse.
    next_cycle();
    bus_if.ext_rstn = 2'b01;
    next_cycle();
    bus_if.ext_rstn = 2'b11;
    fall_k = 0;
    grise_k = 0;
    for (int k = 1; k <= 24; k++) begin
      @(negedge bus_clk);
      if (bus_if.global_rst_n === 1'b0 && fall_k == 0) fall_k = k;
      if (bus_if.global_rst_n === 1'b1 && fall_k != 0 && grise_k == 0) grise_k = k;
      if (k == 4) check("ext_all_low", int'(bus_if.rst_n), 0);
    end
    check("ext_global_fall", fall_k, 3);
    check("ext_global_rise", grise_k, 19);
    check("ext_retrig", int'(bus_if.retrig_cnt), 6);
    wait_all_up(80);

    // Toggling cond[0] keeps channel 0 from ever completing its release.
    next_cycle();
    bus_if.sw_rst_req = 3'b001;
    next_cycle();
    bus_if.sw_rst_req = '0;
    seen = 1'b0;
    for (int k = 0; k < 30; k++) begin
      bus_if.cond[0] = ~bus_if.cond[0];
      @(negedge bus_clk);
      if (bus_if.rst_n[0] !== 1'b0) seen = 1'b1;
      next_cycle();
    end
    bus_if.cond = 4'hf;
    check("toggle_no_rise", int'(seen), 0);
    check("toggle_retrig", int'(bus_if.retrig_cnt), 9);
    wait_all_up(80);

    // 100 rounds of 3 retriggers: counter must pin at 255.
    for (int r = 0; r < 100; r++) begin
      next_cycle();
      bus_if.sw_rst_req = 3'b111;
      next_cycle();
      bus_if.sw_rst_req = '0;
      wait_all_up(80);
    end
    check("retrig_saturate", int'(bus_if.retrig_cnt), 255);

    // bus_reset in the middle of a cascade.
    next_cycle();
    bus_if.sw_rst_req = 3'b001;
    next_cycle();
    bus_if.sw_rst_req = '0;
    next_cycle();
    bus_reset = 1'b1;
    t0 = cyc;
    @(posedge bus_clk);
    @(negedge bus_clk);
    check("midreset_cycle", cyc - t0, 1);
    check("midreset_rst_n", int'(bus_if.rst_n), 0);
    check("midreset_global", int'(bus_if.global_rst_n), 0);
    check("midreset_retrig", int'(bus_if.retrig_cnt), 0);
    next_cycle();
    bus_reset = 1'b0;
    repeat (5) next_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule
